// File: rtl/hamming_serial_rx.sv
// hamming_serial_rx: UART-style deserialiser for Hamming(7,4) codewords.
// It receives a start bit, 7 data bits LSB first, an optional parity bit and a stop bit.
// It presents the codeword in parallel with a one-cycle m_valid strobe.
// It also raises one-cycle strobes for framing errors and, optionally, parity errors.
// Optional feature: define HAMMING_RX_PARITY_EN to expect an 8th bit carrying even
// parity over the data bits. Without that macro there is no PARITY state and
// parity_err is tied low.
module hamming_serial_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [6:0] m_out,
    output logic       m_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'((CLKS_PER_BIT / 2) - 1);

`ifdef HAMMING_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
`endif

    // Even parity over the seven data bits: 1 when the count of ones is odd.
    function automatic logic even_parity(input logic [6:0] d);
        return ^d;
    endfunction

    state_t            state_q;
    logic              rx_meta_q;
    logic              rx_s_q;
    logic              rx_prev_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bitcnt_q;
    logic [6:0]        shift_q;
    logic [6:0]        m_out_q;
    logic              m_valid_q;
    logic              frame_err_q;
    logic              busy_q;
    logic              baud_last_s;
`ifdef HAMMING_RX_PARITY_EN
    logic              par_bit_q;
    logic              parity_err_q;
`endif

    assign baud_last_s = (baud_q == BAUD_LAST);

    assign m_out     = m_out_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef HAMMING_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Two-flop synchroniser for the asynchronous rx pin plus a delayed copy for edge detection.
    // All three flops reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Receive FSM: it walks through the bit times, samples mid-bit and produces registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bitcnt_q    <= 3'd0;
            shift_q     <= 7'd0;
            m_out_q     <= 7'd0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef HAMMING_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // Strobes are high for one cycle only unless re-asserted below.
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef HAMMING_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    baud_q   <= '0;
                    bitcnt_q <= 3'd0;
                    // Needs a genuine 1->0 transition, so a line held low after a frame error stays idle.
                    if (rx_prev_q && !rx_s_q) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_q == HALF_LAST) begin
                        baud_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= ST_DATA;
                        end else begin
                            // Start bit did not survive to mid-bit: treat it as a glitch.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last_s) begin
                        baud_q <= '0;
                        // LSB arrives first, so after seven shifts it lands in bit 0.
                        shift_q <= {rx_s_q, shift_q[6:1]};
                        if (bitcnt_q == 3'd6) begin
                            bitcnt_q <= 3'd0;
`ifdef HAMMING_RX_PARITY_EN
                            state_q  <= ST_PARITY;
`else
                            state_q  <= ST_STOP;
`endif
                        end else begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`ifdef HAMMING_RX_PARITY_EN
                ST_PARITY: begin
                    if (baud_last_s) begin
                        baud_q    <= '0;
                        par_bit_q <= rx_s_q;
                        state_q   <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_last_s) begin
                        baud_q  <= '0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (rx_s_q) begin
                            m_out_q   <= shift_q;
                            m_valid_q <= 1'b1;
`ifdef HAMMING_RX_PARITY_EN
                            parity_err_q <= even_parity(shift_q) ^ par_bit_q;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    baud_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifndef HAMMING_RX_PARITY_EN
    // The parity helper is only referenced in the parity build.
    logic unused_par_s;
    assign unused_par_s = even_parity(7'd0);
`endif

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Self-checking bench for hamming_serial_rx with CLKS_PER_BIT=4.
// Expected strobes are queued when a frame is driven and checked when the DUT strobes.
module tb_hamming_serial_rx;

    localparam int CPB = 4;
`ifdef HAMMING_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    // The first stop-bit strobe is seen at this many clocks after the start bit is driven.
    // The count is 2 synchroniser flops, 1 edge-detect cycle, half a bit of start bit,
    // then 7 data bits, the optional parity bit and the stop bit at one bit time each.
    localparam int LAT = 3 + CPB / 2 + (8 + PAR_EN) * CPB;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [6:0] m_out;
    logic       m_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0] strobes;  // {parity_err, frame_err, m_valid}
        logic [6:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mv_prev = 1'b0;
    logic fe_prev = 1'b0;
    logic seen;

    hamming_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .m_out      (m_out),
        .m_valid    (m_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pop one expected event per strobe and check the pulse width.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid || frame_err || parity_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {29'd0, parity_err, frame_err, m_valid}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("strobes", {29'd0, parity_err, frame_err, m_valid}, {29'd0, mon_e.strobes});
                    check("latency", cyc, mon_e.cyc);
                    if (m_valid) check("m_out", {25'd0, m_out}, {25'd0, mon_e.data});
                end
            end
            if (mv_prev || fe_prev) check("pulse_width", {30'd0, frame_err, m_valid}, 32'd0);
            mv_prev <= m_valid;
            fe_prev <= frame_err;
        end else begin
            mv_prev <= 1'b0;
            fe_prev <= 1'b0;
        end
    end

    // Each task is entered and left 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [6:0] d, input logic stop, input logic bad_par);
        exp_t x;
        x.cyc  = cyc + LAT;
        x.data = d;
        if (stop) x.strobes = {bad_par, 1'b0, 1'b1};
        else      x.strobes = 3'b010;
        sb.push_back(x);
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(d[i]);
`ifdef HAMMING_RX_PARITY_EN
        drive_bit((^d) ^ bad_par);
`endif
        drive_bit(stop);
    endtask

    initial begin
        logic [6:0] part;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_m_out", {25'd0, m_out}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_parity_err", {31'd0, parity_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Idle line: nothing happens.
        idle(100);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_m_out", {25'd0, m_out}, 32'd0);

        // Single good frame.
        send_frame(7'h55, 1'b1, 1'b0);
        idle(8);
        check("frame55_m_out", {25'd0, m_out}, 32'h55);

        // One-clock glitch: busy briefly, then idle, no strobe.
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (busy) seen = 1'b1;
        end
        check("glitch_busy_seen", {31'd0, seen}, 32'd1);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);
        idle(5);

        // Good frame, then a frame with a low stop bit and the line held low afterwards.
        send_frame(7'h2A, 1'b1, 1'b0);
        send_frame(7'h13, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("held_low_busy", {31'd0, busy}, 32'd0);
        idle(8);
        check("frame_err_m_out", {25'd0, m_out}, 32'h2A);

        // Back-to-back frames with zero idle gap.
        send_frame(7'h7F, 1'b1, 1'b0);
        send_frame(7'h01, 1'b1, 1'b0);
        idle(8);
        check("b2b_m_out", {25'd0, m_out}, 32'h01);

        // Reset during data bit 3 discards the partial frame.
        part = 7'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(part[i]);
        rx = part[3];
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_m_out", {25'd0, m_out}, 32'd0);
        idle(20);
        send_frame(7'h0C, 1'b1, 1'b0);
        idle(8);
        check("after_rst_m_out", {25'd0, m_out}, 32'h0C);

`ifdef HAMMING_RX_PARITY_EN
        // Wrong parity bit gives m_valid and parity_err together; the correct bit gives m_valid only.
        send_frame(7'h03, 1'b1, 1'b1);
        idle(4);
        send_frame(7'h03, 1'b1, 1'b0);
        idle(8);
        check("parity_m_out", {25'd0, m_out}, 32'h03);
`endif

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
